// File: rtl/loteria_pkg.sv
// Shared types, widths and scoring tables for the two-player lottery scorer.
package loteria_pkg;

   localparam int unsigned NUM_W    = 4;
   localparam int unsigned POS_W    = 2;
   localparam int unsigned HITS_W   = 3;
   localparam int unsigned PTS_W    = 4;
   localparam int unsigned SCORE_W  = 5;
   localparam int unsigned PREMIO_W = 2;
   localparam int unsigned STATE_W  = 1;
   localparam int unsigned BET_LEN  = 4;

   localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'(31);

   // Game states
   localparam logic [STATE_W-1:0] ST_PLAY = 1'b0;
   localparam logic [STATE_W-1:0] ST_OVER = 1'b1;

   // Prize classes
   localparam logic [PREMIO_W-1:0] PREMIO_NONE  = 2'b00;
   localparam logic [PREMIO_W-1:0] PREMIO_TWO   = 2'b01;
   localparam logic [PREMIO_W-1:0] PREMIO_THREE = 2'b10;
   localparam logic [PREMIO_W-1:0] PREMIO_FOUR  = 2'b11;

   function automatic logic [PREMIO_W-1:0] class_of(input logic [HITS_W-1:0] hits);
      case (hits)
         3'd0, 3'd1: class_of = PREMIO_NONE;
         3'd2:       class_of = PREMIO_TWO;
         3'd3:       class_of = PREMIO_THREE;
         default:    class_of = PREMIO_FOUR;
      endcase
   endfunction

   // Points table: 0,1,2,4,8 for 0..4 hits
   function automatic logic [PTS_W-1:0] pts_of(input logic [HITS_W-1:0] hits);
      case (hits)
         3'd0:    pts_of = 4'd0;
         3'd1:    pts_of = 4'd1;
         3'd2:    pts_of = 4'd2;
         3'd3:    pts_of = 4'd4;
         default: pts_of = 4'd8;
      endcase
   endfunction

endpackage

// File: rtl/loteria_if.sv
// Bet entry / result bus between the game controller and the scorer.
interface loteria_if;
   import loteria_pkg::*;

   logic [NUM_W-1:0]    numero;
   logic                insere;
   logic                fim;
   logic                fim_jogo;
   logic [PREMIO_W-1:0] premio;
   logic [SCORE_W-1:0]  p1;
   logic [SCORE_W-1:0]  p2;

   modport master (output numero, insere, fim, fim_jogo, input premio, p1, p2);
   modport slave  (input numero, insere, fim, fim_jogo, output premio, p1, p2);
endinterface

// File: rtl/loteria_score.sv
// Combinational bet evaluation: hit count -> prize class, and saturating score update.
module loteria_score
   import loteria_pkg::*;
(
   input  logic [HITS_W-1:0]   hits,
   input  logic [SCORE_W-1:0]  score,
   output logic [PREMIO_W-1:0] premio_c,
   output logic [SCORE_W-1:0]  sum_c
);

   localparam int unsigned SUM_W = SCORE_W + 1;

   logic [PTS_W-1:0] pts;
   logic [SUM_W-1:0] sum_wide;

   always_comb begin
      pts      = pts_of(hits);
      premio_c = class_of(hits);
      sum_wide = SUM_W'(score) + SUM_W'(pts);
      sum_c    = (sum_wide > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum_wide[SCORE_W-1:0];
   end

endmodule

// File: rtl/loteria.sv
// Two-player lottery scorer: collects 4-number bets, scores them against SECRET, tracks per-player points.
module loteria
   import loteria_pkg::*;
#(
   parameter logic [15:0] SECRET = 16'h2830
)(
   input  logic clock,
   input  logic reset,
   loteria_if.slave bus
);

   logic [STATE_W-1:0]  state_q, state_n;
   logic [POS_W-1:0]    pos_q, pos_n;
   logic [HITS_W-1:0]   hits_q, hits_n;
   logic                turn_q, turn_n;
   logic [PREMIO_W-1:0] premio_q, premio_n;
   logic [SCORE_W-1:0]  p1_q, p1_n;
   logic [SCORE_W-1:0]  p2_q, p2_n;

   logic [NUM_W-1:0]    secret_nib;
   logic                hit;
   logic [HITS_W-1:0]   hits_next;
   logic [SCORE_W-1:0]  score_cur;
   logic [PREMIO_W-1:0] class_c;
   logic [SCORE_W-1:0]  sum_c;
   logic                bet_close;

   // Hit detection for the number offered this cycle; turn_q=0 is player 1
   assign secret_nib = SECRET[{pos_q, 2'b00} +: NUM_W];
   assign hit        = bus.insere && (bus.numero == secret_nib);
   assign hits_next  = hits_q + HITS_W'(hit);
   assign score_cur  = turn_q ? p2_q : p1_q;

   loteria_score u_score (
      .hits     (hits_next),
      .score    (score_cur),
      .premio_c (class_c),
      .sum_c    (sum_c)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_PLAY;
         pos_q    <= '0;
         hits_q   <= '0;
         turn_q   <= 1'b0;
         premio_q <= PREMIO_NONE;
         p1_q     <= '0;
         p2_q     <= '0;
      end else begin
         state_q  <= state_n;
         pos_q    <= pos_n;
         hits_q   <= hits_n;
         turn_q   <= turn_n;
         premio_q <= premio_n;
         p1_q     <= p1_n;
         p2_q     <= p2_n;
      end
   end

   always_comb begin
      state_n   = state_q;
      pos_n     = pos_q;
      hits_n    = hits_q;
      turn_n    = turn_q;
      premio_n  = premio_q;
      p1_n      = p1_q;
      p2_n      = p2_q;
      bet_close = 1'b0;

      case (state_q)
         ST_PLAY: begin
            if (bus.fim_jogo) begin
               // Game ends: any unclosed bet is dropped unscored
               state_n = ST_OVER;
               pos_n   = '0;
               hits_n  = '0;
            end else begin
               bet_close = (bus.insere && (pos_q == POS_W'(BET_LEN - 1))) ||
                           (bus.fim && (bus.insere || (pos_q != '0)));
               if (bus.insere) begin
                  pos_n  = pos_q + POS_W'(1);
                  hits_n = hits_next;
               end
               if (bet_close) begin
                  premio_n = class_c;
                  if (turn_q) p2_n = sum_c;
                  else        p1_n = sum_c;
                  pos_n  = '0;
                  hits_n = '0;
                  turn_n = ~turn_q;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.premio = premio_q;
   assign bus.p1     = p1_q;
   assign bus.p2     = p2_q;

endmodule

// File: tb/tb_loteria.sv
// Directed self-checking bench for the loteria scorer.
module tb_loteria;

   logic clock;
   logic reset;
   int   total;
   int   passed;

   loteria_if bus ();

   loteria dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic drive(input logic ins, input logic [3:0] num, input logic f, input logic fj);
      bus.insere   = ins;
      bus.numero   = num;
      bus.fim      = f;
      bus.fim_jogo = fj;
      @(posedge clock);
      #1;
      bus.insere   = 1'b0;
      bus.fim      = 1'b0;
      bus.fim_jogo = 1'b0;
   endtask

   task automatic put(input logic [3:0] n);
      drive(1'b1, n, 1'b0, 1'b0);
   endtask

   task automatic bet(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] c, input logic [3:0] d);
      put(a); put(b); put(c); put(d);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic chk3(input string tag, input int pr, input int s1, input int s2);
      chk({tag, ".premio"}, int'(bus.premio), pr);
      chk({tag, ".p1"}, int'(bus.p1), s1);
      chk({tag, ".p2"}, int'(bus.p2), s2);
   endtask

   initial begin
      total        = 0;
      passed       = 0;
      reset        = 1'b1;
      bus.numero   = 4'd0;
      bus.insere   = 1'b0;
      bus.fim      = 1'b0;
      bus.fim_jogo = 1'b0;

      // 1: reset then a perfect bet for player 1
      do_reset();
      chk3("reset", 0, 0, 0);
      put(4'd0); put(4'd3); put(4'd8);
      chk3("t1_mid", 0, 0, 0);
      put(4'd2);
      chk3("t1_close", 3, 8, 0);

      // 2: player 2 partial, then end of game with insere/fim also high
      put(4'd0); put(4'd0);
      drive(1'b1, 4'd8, 1'b1, 1'b1);
      chk3("t2_over", 3, 8, 0);
      for (int i = 0; i < 20; i++) begin
         drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         chk3("t2_hold", 3, 8, 0);
      end

      // 3: two-hit bet for player 1, three-hit bet for player 2
      do_reset();
      chk3("t3_reset", 0, 0, 0);
      bet(4'd0, 4'd3, 4'd1, 4'd1);
      chk3("t3_bet1", 1, 2, 0);
      bet(4'd5, 4'd3, 4'd8, 4'd2);
      chk3("t3_bet2", 2, 2, 4);

      // 4: early close, empty-bet fim, then fim together with a number
      do_reset();
      put(4'd0); put(4'd3);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      chk3("t4_early", 1, 2, 0);
      drive(1'b0, 4'd0, 1'b1, 1'b0);
      chk3("t4_empty_fim", 1, 2, 0);
      bet(4'd0, 4'd3, 4'd8, 4'd2);
      chk3("t4_p2_turn", 3, 2, 8);
      drive(1'b1, 4'd0, 1'b1, 1'b0);
      chk3("t4_fim_ins", 0, 3, 8);

      // 5: saturation at 31
      do_reset();
      for (int i = 0; i < 6; i++) bet(4'd0, 4'd3, 4'd8, 4'd2);
      chk3("t5_six", 3, 24, 24);
      for (int i = 0; i < 2; i++) bet(4'd0, 4'd3, 4'd8, 4'd2);
      chk3("t5_eight", 3, 31, 31);
      bet(4'd0, 4'd3, 4'd8, 4'd2);
      chk3("t5_nine", 3, 31, 31);

      // 6: reset mid-bet discards partial and returns turn to player 1
      do_reset();
      bet(4'd0, 4'd0, 4'd0, 4'd0);
      chk3("t6_p1_one", 0, 1, 0);
      put(4'd0); put(4'd3);
      do_reset();
      chk3("t6_reset", 0, 0, 0);
      bet(4'd0, 4'd3, 4'd8, 4'd2);
      chk3("t6_after", 3, 8, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
